uart_rx_calc: RTL and testbench

UART_RX_CALC -- requirements
Module: uart_rx_calc

---
 rtl/calc_uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_calc.sv | 78 +++++++
 tb/tb_uart_rx_calc.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/calc_uart_pkg.sv
// calc_uart_pkg: shared UART state encodings, frame constants and bit-timing derivation
// Shared by uart_rx_calc and transmitter_calc.
//   state_t        : IDLE / START / DATA / STOP
//   DATA_BITS      : data bits per frame (8, LSB first)
//   STOP_BITS      : stop bits per frame (1)
//   clks_per_bit() : CLK_FREQ/BIT_RATE (integer division)
//   half_bit()     : clks_per_bit()/2, the offset to the middle of the start bit
`timescale 1ns/1ps
package calc_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  function automatic int clks_per_bit(input int clk_freq, input int bit_rate);
    return clk_freq / bit_rate;
  endfunction
  function automatic int half_bit(input int clk_freq, input int bit_rate);
    return clks_per_bit(clk_freq, bit_rate) / 2;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with parameterized reset value
//   clk   : destination clock
//   reset : asynchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output, 2 cycles of latency
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/uart_rx_calc.sv
// uart_rx_calc: 8N1 UART receiver with valid/ready output, frame error and overrun pulses
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   rxd_pin   : asynchronous serial line, idle high
//   rx_data   : last correctly received byte
//   rx_valid  : rx_data holds an unconsumed byte
//   rx_ready  : consumer accepts rx_data when rx_valid & rx_ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte dropped because rx_valid was still held
//   busy      : receiver is inside a frame
`timescale 1ns/1ps
module uart_rx_calc #(
  parameter int CLK_FREQ = 100000000,
  parameter int BIT_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  import calc_uart_pkg::*;
  localparam int CPB  = clks_per_bit(CLK_FREQ, BIT_RATE);
  localparam int HALF = half_bit(CLK_FREQ, BIT_RATE);
  localparam int CW   = $clog2(CPB) + 1;
  localparam int IW   = $clog2(DATA_BITS);
  state_t state, next;
  logic rx_s, rx_d, fall, tick, stop_tick, stop_ok;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shift;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rxd_pin), .q(rx_s));
  assign fall      = rx_d & ~rx_s;
  // START waits half a bit to land mid start bit; every later sample is a full bit apart
  assign tick      = (state == START) ? (cnt == CW'(HALF - 1)) : (cnt == CW'(CPB - 1));
  assign stop_tick = (state == STOP) && tick;
  assign stop_ok   = stop_tick & rx_s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = fall ? START : IDLE;
      START:   next = tick ? (rx_s ? IDLE : DATA) : START;
      DATA:    next = (tick && idx == IW'(DATA_BITS - 1)) ? STOP : DATA;
      default: next = tick ? IDLE : STOP;
    endcase
  end
  always_comb busy = (state != IDLE);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_d      <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_d      <= rx_s;
      cnt       <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      idx       <= (state != DATA) ? '0 : tick ? idx + IW'(1) : idx;
      if (state == DATA && tick) shift[idx] <= rx_s;
      frame_err <= stop_tick & ~rx_s;
      overrun   <= stop_ok & rx_valid & ~rx_ready;
      // a handshake in the stop-sample cycle frees the slot, so the new byte still lands
      if (stop_ok & (~rx_valid | rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_calc.sv
// tb_uart_rx_calc: directed self-checking bench for uart_rx_calc
`timescale 1ns/1ps
module tb_uart_rx_calc;
  localparam int CLK_FREQ = 100000000;
  localparam int BIT_RATE = 250000;
  localparam int BIT_NS   = 4000;
  localparam int LAT      = 3803;
  logic clk, reset_n, rxd, rx_ready;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int checks, errors, fe_n, ov_n, lat, fe0, ov0;
  logic [7:0] acc_q[$];
  uart_rx_calc #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE)) dut (
    .clk(clk), .reset(reset_n), .rxd_pin(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) fe_n++;
    if (overrun) ov_n++;
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #BIT_NS;
    end
    rxd = stop;
    #BIT_NS;
    rxd = 1'b1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!rx_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic consume;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  initial begin
    checks = 0; errors = 0; fe_n = 0; ov_n = 0;
    rxd = 1'b1; rx_ready = 1'b0; reset_n = 1'b0;
    #52;
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    #100;
    @(negedge clk);
    fork
      send_byte(8'h61, 1'b1);
      wait_valid(lat);
    join
    check("a_latency", lat, LAT);
    check("a_data", rx_data, 8'h61);
    check("a_valid", rx_valid, 1);
    check("a_ferr", fe_n, 0);
    check("a_ovr", ov_n, 0);
    consume();
    check("a_consumed", rx_valid, 0);
    rx_ready = 1'b1;
    acc_q.delete();
    ov0 = ov_n;
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    #BIT_NS;
    check("b2b_count", acc_q.size(), 2);
    check("b2b_first", acc_q.size() > 0 ? acc_q[0] : 8'hxx, 8'h61);
    check("b2b_second", acc_q.size() > 1 ? acc_q[1] : 8'hxx, 8'h62);
    check("b2b_ovr", ov_n - ov0, 0);
    check("b2b_valid", rx_valid, 0);
    rx_ready = 1'b0;
    fe0 = fe_n;
    rxd = 1'b0;
    #500;
    check("glitch_busy", busy, 1);
    #500;
    rxd = 1'b1;
    #3000;
    check("glitch_idle", busy, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", fe_n - fe0, 0);
    send_byte(8'h55, 1'b0);
    #BIT_NS;
    check("ferr_pulses", fe_n - fe0, 1);
    check("ferr_valid", rx_valid, 0);
    check("ferr_busy", busy, 0);
    ov0 = ov_n;
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    #BIT_NS;
    check("ovr_pulses", ov_n - ov0, 1);
    check("ovr_data", rx_data, 8'h61);
    check("ovr_valid", rx_valid, 1);
    @(negedge clk);
    rxd = 1'b0;
    #BIT_NS;
    rxd = 1'b1;
    #2000;
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 8'h00);
    #100;
    reset_n = 1'b1;
    fe0 = fe_n;
    ov0 = ov_n;
    #(2 * BIT_NS);
    check("post_rst_idle", busy, 0);
    @(negedge clk);
    fork
      send_byte(8'h33, 1'b1);
      wait_valid(lat);
    join
    check("r33_latency", lat, LAT);
    check("r33_data", rx_data, 8'h33);
    check("r33_ferr", fe_n - fe0, 0);
    check("r33_ovr", ov_n - ov0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
